// File: rtl/gate_input_debouncer_if.sv
// Signal bundle between raw switch inputs and the debouncer: raw levels in, clean levels,
// edge pulses and a per-channel FSM state view out.
interface gate_input_debouncer_if;
    logic       a_raw;
    logic       b_raw;
    logic       a;
    logic       b;
    logic       a_rise;
    logic       a_fall;
    logic       b_rise;
    logic       b_fall;
    logic [3:0] dbg_state;   // {b_state, a_state}

    modport master (
        output a_raw, b_raw,
        input  a, b, a_rise, a_fall, b_rise, b_fall, dbg_state
    );

    modport slave (
        input  a_raw, b_raw,
        output a, b, a_rise, a_fall, b_rise, b_fall, dbg_state
    );
endinterface

// File: rtl/gate_input_debouncer.sv
// Two independent channels: 2-flop synchroniser + stability FSM per input, giving clean levels.
// Define GATE_DEBOUNCE_EDGE_EN to build the registered rise/fall pulses; otherwise they read 0.
module gate_input_debouncer #(
    parameter int STABLE_CNT = 50000,
    parameter int CNT_W      = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    gate_input_debouncer_if.slave  bus
);

    localparam logic [1:0] IDLE_LO = 2'd0;
    localparam logic [1:0] WAIT_HI = 2'd1;
    localparam logic [1:0] IDLE_HI = 2'd2;
    localparam logic [1:0] WAIT_LO = 2'd3;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

    logic [1:0] w_raw;
    logic [1:0] w_out;
    logic [1:0] w_rise;
    logic [1:0] w_fall;
    logic [3:0] w_state;

    assign w_raw = {bus.b_raw, bus.a_raw};

    for (genvar g = 0; g < 2; g++) begin : g_ch
        logic             r_s1;
        logic             r_s2;
        logic             r_out;
        logic [1:0]       r_state;
        logic [CNT_W-1:0] r_cnt;
        logic             w_hit;

        assign w_hit = (r_cnt == CNT_LAST);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_s1 <= 1'b0;
                r_s2 <= 1'b0;
            end else begin
                r_s1 <= w_raw[g];
                r_s2 <= r_s1;
            end
        end

        // Any opposite-level sample while waiting drops the whole accumulated count.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_state <= IDLE_LO;
                r_cnt   <= '0;
                r_out   <= 1'b0;
            end else begin
                case (r_state)
                    IDLE_LO: begin
                        if (r_s2) begin
                            r_state <= WAIT_HI;
                            r_cnt   <= '0;
                        end
                    end
                    WAIT_HI: begin
                        if (!r_s2) begin
                            r_state <= IDLE_LO;
                            r_cnt   <= '0;
                        end else if (w_hit) begin
                            r_state <= IDLE_HI;
                            r_out   <= 1'b1;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    IDLE_HI: begin
                        if (!r_s2) begin
                            r_state <= WAIT_LO;
                            r_cnt   <= '0;
                        end
                    end
                    WAIT_LO: begin
                        if (r_s2) begin
                            r_state <= IDLE_HI;
                            r_cnt   <= '0;
                        end else if (w_hit) begin
                            r_state <= IDLE_LO;
                            r_out   <= 1'b0;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        r_state <= IDLE_LO;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end

        assign w_out[g]           = r_out;
        assign w_state[2*g +: 2]  = r_state;

`ifdef GATE_DEBOUNCE_EDGE_EN
        logic r_rise;
        logic r_fall;

        // Pulses are registered alongside r_out so they coincide with the level change.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_rise <= 1'b0;
                r_fall <= 1'b0;
            end else begin
                r_rise <= (r_state == WAIT_HI) && r_s2 && w_hit;
                r_fall <= (r_state == WAIT_LO) && !r_s2 && w_hit;
            end
        end

        assign w_rise[g] = r_rise;
        assign w_fall[g] = r_fall;
`else
        assign w_rise[g] = 1'b0;
        assign w_fall[g] = 1'b0;
`endif
    end

    assign bus.a         = w_out[0];
    assign bus.b         = w_out[1];
    assign bus.a_rise    = w_rise[0];
    assign bus.a_fall    = w_fall[0];
    assign bus.b_rise    = w_rise[1];
    assign bus.b_fall    = w_fall[1];
    assign bus.dbg_state = w_state;

endmodule

// File: tb/tb_gate_input_debouncer.sv
// Bench for gate_input_debouncer (STABLE_CNT=4, CNT_W=3): directed latency checks plus
// randomized raw levels compared every cycle against a run-length model of the debouncer.
module tb_gate_input_debouncer;
    localparam int S = 4;
`ifdef GATE_DEBOUNCE_EDGE_EN
    localparam logic EDGE = 1'b1;
`else
    localparam logic EDGE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gate_input_debouncer_if ifc();

    gate_input_debouncer #(.STABLE_CNT(S), .CNT_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int n_arise  = 0;
    logic cmp_en = 1'b0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%02h expected=%02h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] dut_vec();
        return {2'b00, ifc.a, ifc.b, ifc.a_rise, ifc.a_fall, ifc.b_rise, ifc.b_fall};
    endfunction

    // Model: an output flips once its synchronised input has disagreed with it for S+1 consecutive edges.
    logic [1:0] m_s1 = '0, m_s2 = '0, m_out = '0, m_rise = '0, m_fall = '0;
    int         m_run [2] = '{0, 0};
    logic [7:0] exp_q[$];
    logic [7:0] cur_exp = '0;

    always @(posedge clk or negedge rst_n) begin
        logic [1:0] raw;
        if (!rst_n) begin
            m_s1 = '0; m_s2 = '0; m_out = '0; m_rise = '0; m_fall = '0;
            m_run[0] = 0; m_run[1] = 0;
        end else begin
            raw = {ifc.b_raw, ifc.a_raw};
            for (int ch = 0; ch < 2; ch++) begin
                m_rise[ch] = 1'b0;
                m_fall[ch] = 1'b0;
                if (m_s2[ch] != m_out[ch]) begin
                    m_run[ch]++;
                    if (m_run[ch] == S + 1) begin
                        m_out[ch]  = m_s2[ch];
                        m_rise[ch] = EDGE & m_s2[ch];
                        m_fall[ch] = EDGE & ~m_s2[ch];
                        m_run[ch]  = 0;
                    end
                end else begin
                    m_run[ch] = 0;
                end
            end
            m_s2 = m_s1;
            m_s1 = raw;
        end
        exp_q.push_back({2'b00, m_out[0], m_out[1], m_rise[0], m_fall[0], m_rise[1], m_fall[1]});
    end

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            cur_exp = exp_q[$];
            exp_q.delete();
        end
        if (ifc.a_rise) n_arise++;
        if (cmp_en) chk("model", dut_vec(), cur_exp);
    end

    task automatic drive(input logic a_v, input logic b_v);
        ifc.a_raw = a_v;
        ifc.b_raw = b_v;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int cnt0;
        int hold_a, hold_b;
        ifc.a_raw = 1'b1;
        ifc.b_raw = 1'b1;
        tick(3);
        chk("reset_hold", dut_vec(), 8'h00);
        cmp_en = 1'b1;

        // Release reset with both raws high: rise at edge 7 after release.
        rst_n = 1'b1;
        tick(6);
        chk("rst_rel_pre", dut_vec(), 8'h00);
        tick(1);
        chk("rst_rel_rise", dut_vec(), {2'b00, 1'b1, 1'b1, EDGE, 1'b0, EDGE, 1'b0});
        tick(1);
        chk("rst_rel_after", dut_vec(), 8'h30);

        drive(1'b0, 1'b0);
        tick(10);
        chk("both_low", dut_vec(), 8'h00);

        // Clean step on A only.
        drive(1'b1, 1'b0);
        tick(6);
        chk("step_pre", dut_vec(), 8'h00);
        tick(1);
        chk("step_rise", dut_vec(), {2'b00, 1'b1, 1'b0, EDGE, 3'b000});
        tick(1);
        chk("step_after", dut_vec(), 8'h20);

        drive(1'b0, 1'b0);
        tick(10);
        chk("a_fall_done", dut_vec(), 8'h00);

        // Bounce 1,0,1,0 every 2 cycles, then hold 1.
        cnt0 = n_arise;
        drive(1'b1, 1'b0); tick(2);
        drive(1'b0, 1'b0); tick(2);
        drive(1'b1, 1'b0); tick(2);
        drive(1'b0, 1'b0); tick(2);
        chk("bounce_low", dut_vec(), 8'h00);
        drive(1'b1, 1'b0);
        tick(6);
        chk("bounce_pre", dut_vec(), 8'h00);
        tick(1);
        chk("bounce_rise", dut_vec(), {2'b00, 1'b1, 1'b0, EDGE, 3'b000});
        tick(3);
        chk("bounce_nrise", 8'(n_arise - cnt0), {7'd0, EDGE});

        drive(1'b0, 1'b0);
        tick(10);

        // Three-cycle pulse is too short to pass.
        cnt0 = n_arise;
        drive(1'b1, 1'b0); tick(3);
        drive(1'b0, 1'b0); tick(12);
        chk("short_level", dut_vec(), 8'h00);
        chk("short_nrise", 8'(n_arise - cnt0), 8'd0);

        // Opposite simultaneous edges on A and B.
        drive(1'b0, 1'b1);
        tick(10);
        chk("b_high", dut_vec(), 8'h10);
        drive(1'b1, 1'b0);
        tick(6);
        chk("simul_pre", dut_vec(), 8'h10);
        tick(1);
        chk("simul_edge", dut_vec(), {2'b00, 1'b1, 1'b0, EDGE, 2'b00, EDGE});

        // Mid-WAIT asynchronous reset with B high.
        drive(1'b0, 1'b1);
        tick(12);
        chk("pre_midrst", dut_vec(), 8'h10);
        drive(1'b1, 1'b1);
        tick(5);
        #2 rst_n = 1'b0;
        #1 chk("midrst_clear", dut_vec(), 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        tick(6);
        chk("midrst_pre", dut_vec(), 8'h00);
        tick(1);
        chk("midrst_rise", dut_vec(), {2'b00, 1'b1, 1'b1, EDGE, 1'b0, EDGE, 1'b0});

        // Random raw levels with hold lengths around the stability window.
        hold_a = 0;
        hold_b = 0;
        for (int i = 0; i < 3000; i++) begin
            if (hold_a == 0) begin
                ifc.a_raw = 1'($urandom_range(0, 1));
                hold_a = $urandom_range(1, 9);
            end
            if (hold_b == 0) begin
                ifc.b_raw = 1'($urandom_range(0, 1));
                hold_b = $urandom_range(1, 9);
            end
            hold_a--;
            hold_b--;
            if ($urandom_range(0, 599) == 0) begin
                #3 rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
            tick(1);
        end

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
